// File: rtl/mips_cpu_pkg.sv
// Shared types and helpers for the MIPS core's multiply/divide unit.
package mips_cpu_pkg;

    // Encodings of the op field driven by the core's decoder.
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        MD_MULT  = OP_MULT,
        MD_MULTU = OP_MULTU,
        MD_DIV   = OP_DIV,
        MD_DIVU  = OP_DIVU,
        MD_MTHI  = OP_MTHI,
        MD_MTLO  = OP_MTLO
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } muldiv_state_t;

    // Iteration counter width: must hold the value WIDTH itself.
    function automatic int muldiv_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Core <-> multiply/divide unit bus. op is carried as raw bits so that
// unused encodings reach the unit and can be rejected there.
interface mips_cpu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_divider.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per
// step. Sign handling and the divide-by-zero result belong to the parent.
module mips_cpu_muldiv_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Trial subtraction of the divisor from the partial remainder shifted left by one.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        // When the divisor fits, the difference is below the divisor, so WIDTH bits suffice.
        diff    = shifted[WIDTH-1:0] - dvs_q;
        fits    = shifted >= {1'b0, dvs_q};
    end

    // Remainder/quotient shift registers; the dividend is shifted out as quotient bits come in.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: datapath registers are reset too, so an op aborted by reset leaves no residue.
        if (!reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments here, so every register samples pre-edge values.
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= fits ? diff : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], fits};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit owning HI/LO. Multiplies retire MUL_STEP
// multiplier bits per cycle with shift-add on magnitudes; divides use the
// restoring divider sub-module. Sign correction happens in one FIX cycle.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    mips_cpu_muldiv_if.slave  bus
);
    localparam int             CW    = muldiv_cnt_width(WIDTH);
    localparam logic [CW-1:0]  MUL_N = CW'(WIDTH / MUL_STEP);
    localparam logic [CW-1:0]  DIV_N = CW'(WIDTH);

    generate
        if (WIDTH < 4 || !(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4 || MUL_STEP == 8)
            || (WIDTH % MUL_STEP) != 0) begin : g_bad_params
            $error("mips_cpu_muldiv: WIDTH must be >= 4 and divisible by MUL_STEP in {1,2,4,8}");
        end
    endgenerate

    muldiv_state_t      state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    muldiv_op_t         op_in;
    logic               is_mul, is_div, is_signed, idle;
    logic               accept_arith, accept_mthi, accept_mtlo;
    logic               mul_load, div_load, mul_step, div_step, fix_en;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic               is_div_q, neg_q, rem_neg_q, div0_q;
    logic [WIDTH-1:0]   a_q, mcand_q, prod_hi_q, prod_lo_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic [WIDTH+MUL_STEP-1:0] mul_part, mul_sum;
    logic [2*WIDTH-1:0]        prod, mul_res;
    logic [WIDTH-1:0]          div_quo, div_rem, fix_hi, fix_lo;

    // Decode the requested op; unknown encodings decode to nothing and are ignored.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        op_in     = muldiv_op_t'(bus.op);
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        case (op_in)
            MD_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            MD_MULTU: is_mul = 1'b1;
            MD_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            MD_DIVU:  is_div = 1'b1;
            default:  ;
        endcase
    end

    assign idle         = (state_q == ST_IDLE);
    assign accept_arith = clk_enable && bus.start && idle && (is_mul || is_div);
    assign accept_mthi  = clk_enable && bus.start && idle && (op_in == MD_MTHI);
    assign accept_mtlo  = clk_enable && bus.start && idle && (op_in == MD_MTLO);
    assign a_mag        = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag        = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // FSM next state, iteration counter and datapath strobes; everything holds when stalled.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_load = 1'b0;
        div_load = 1'b0;
        mul_step = 1'b0;
        div_step = 1'b0;
        fix_en   = 1'b0;
        if (clk_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_arith) begin
                        state_d  = ST_CALC;
                        cnt_d    = is_div ? DIV_N : MUL_N;
                        mul_load = is_mul;
                        div_load = is_div;
                    end
                end
                ST_CALC: begin
                    cnt_d    = cnt_q - CW'(1);
                    mul_step = !is_div_q;
                    div_step = is_div_q;
                    if (cnt_q == CW'(1)) state_d = ST_FIX;
                end
                ST_FIX: begin
                    fix_en  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture what the FIX cycle needs to know about the accepted op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            a_q       <= '0;
        end else if (mul_load || div_load) begin
            is_div_q  <= is_div;
            neg_q     <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rem_neg_q <= is_signed && bus.a[WIDTH-1];
            div0_q    <= (bus.b == '0);
            a_q       <= bus.a;
        end
    end

    // Shift-add step: add multiplicand times the low MUL_STEP multiplier bits, shift right.
    always_comb begin
        mul_part = {{MUL_STEP{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, prod_lo_q[MUL_STEP-1:0]};
        mul_sum  = mul_part + {{MUL_STEP{1'b0}}, prod_hi_q};
    end

    // Multiply product register; the low half starts as the multiplier and is consumed from the bottom.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q   <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else if (mul_load) begin
            mcand_q   <= a_mag;
            prod_hi_q <= '0;
            prod_lo_q <= b_mag;
        end else if (mul_step) begin
            {prod_hi_q, prod_lo_q} <= (2*WIDTH)'({mul_sum, prod_lo_q} >> MUL_STEP);
        end
    end

    mips_cpu_muldiv_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Sign correction and the divide-by-zero result, consumed in FIX.
    always_comb begin
        prod    = {prod_hi_q, prod_lo_q};
        mul_res = neg_q ? -prod : prod;
        {fix_hi, fix_lo} = mul_res;
        if (is_div_q) begin
            if (div0_q) begin
                fix_lo = '1;
                fix_hi = a_q;
            end else begin
                fix_lo = neg_q     ? -div_quo : div_quo;
                fix_hi = rem_neg_q ? -div_rem : div_rem;
            end
        end
    end

    // HI/LO: written by moves from IDLE or by the FIX cycle; untouched during CALC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fix_en) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else begin
            if (accept_mthi) hi_q <= bus.a;
            if (accept_mtlo) lo_q <= bus.a;
        end
    end

    // Completion pulse, frozen along with everything else during a stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          done_q <= 1'b0;
        else if (clk_enable) done_q <= fix_en;
    end

    assign bus.busy = !idle;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Bench for mips_cpu_muldiv: a 32-bit radix-2 instance and an 8-bit radix-16
// instance, table-driven vectors plus hand sequences, with a result scoreboard.
module tb_mips_cpu_muldiv;
    import mips_cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset32, reset8, ce;

    mips_cpu_muldiv_if #(.WIDTH(32)) bus32();
    mips_cpu_muldiv_if #(.WIDTH(8))  bus8();

    mips_cpu_muldiv #(.WIDTH(32), .MUL_STEP(1)) dut32 (
        .clk(clk), .reset(reset32), .clk_enable(ce), .bus(bus32.slave));
    mips_cpu_muldiv #(.WIDTH(8), .MUL_STEP(4)) dut8 (
        .clk(clk), .reset(reset8), .clk_enable(ce), .bus(bus8.slave));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [63:0] res;
    } sb_t;
    sb_t sb32[$];
    sb_t sb8[$];
    sb_t e32, e8;
    logic d32_prev = 1'b0, d8_prev = 1'b0;

    // Scoreboards: every rising done pops one expected {hi,lo}.
    always @(negedge clk) begin
        if (bus32.done && !d32_prev) begin
            if (sb32.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb32_unexpected_done: got done=1 hi=%h lo=%h want no done", bus32.hi, bus32.lo);
            end else begin
                e32 = sb32.pop_front();
                check(e32.name, {bus32.hi, bus32.lo}, e32.res);
            end
        end
        if (bus8.done && !d8_prev) begin
            if (sb8.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb8_unexpected_done: got done=1 hi=%h lo=%h want no done", bus8.hi, bus8.lo);
            end else begin
                e8 = sb8.pop_front();
                check(e8.name, {48'h0, bus8.hi, bus8.lo}, e8.res);
            end
        end
        d32_prev = bus32.done;
        d8_prev  = bus8.done;
    end

    // Issue one 32-bit op at a negedge and follow it to done. Optional clk_enable
    // stall and an extra start pulse while busy.
    task automatic run32(input string name, input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input int exp_busy,
                         input int stall_at, input int stall_len, input int poke_at);
        int          en_edges = 0, tot_edges = 0, busy_cnt = 0;
        bit          seen = 0, hold_bad = 0;
        logic [63:0] prev;
        prev = {bus32.hi, bus32.lo};
        sb32.push_back(sb_t'{name, exp_res});
        bus32.op = op; bus32.a = a; bus32.b = b; bus32.start = 1'b1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            tot_edges++;
            if (ce) en_edges++;
            @(negedge clk);
            if (i == 0) bus32.start = 1'b0;
            if (i == poke_at) begin bus32.start = 1'b1; bus32.op = MD_MULT; bus32.a = 32'd5; bus32.b = 32'd5; end
            if (i == poke_at + 1) bus32.start = 1'b0;
            if (i == stall_at) ce = 1'b0;
            if (i == stall_at + stall_len) ce = 1'b1;
            if (bus32.busy) busy_cnt++;
            if (bus32.done) seen = 1;
            else if ({bus32.hi, bus32.lo} !== prev) hold_bad = 1;
        end
        bus32.start = 1'b0;
        ce = 1'b1;
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_enabled_edges"}, 64'(en_edges), 64'(exp_busy + 1));
        check({name, "_total_edges"}, 64'(tot_edges), 64'(exp_busy + 1 + stall_len));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy + stall_len));
        check({name, "_hilo_held"}, 64'(hold_bad), 64'd0);
    endtask

    task automatic run8(input string name, input muldiv_op_t op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_res, input int exp_busy);
        int en_edges = 0, busy_cnt = 0;
        bit seen = 0;
        sb8.push_back(sb_t'{name, {48'h0, exp_res}});
        bus8.op = op; bus8.a = a; bus8.b = b; bus8.start = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            en_edges++;
            @(negedge clk);
            bus8.start = 1'b0;
            if (bus8.busy) busy_cnt++;
            if (bus8.done) seen = 1;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_edges"}, 64'(en_edges), 64'(exp_busy + 1));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    endtask

    typedef struct {
        string       name;
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_busy, any_done;

        vecs[0] = '{"mult_m2_x3",    MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{"multu_fffe_x3", MD_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
        vecs[2] = '{"div_m7_2",      MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"divu_7_0",      MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[4] = '{"mult_7_m5",     MD_MULT,  32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD};
        vecs[5] = '{"divu_100_7",    MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[6] = '{"div_7_m2",      MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{"div_m7_0",      MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8] = '{"multu_max_sq",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[9] = '{"mult_minneg_sq",MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        // Reset with a start request pending: it must be ignored.
        ce = 1'b1;
        reset32 = 1'b0; reset8 = 1'b0;
        bus32.start = 1'b1; bus32.op = MD_MULT; bus32.a = 32'd3; bus32.b = 32'd3;
        bus8.start = 1'b0; bus8.op = MD_MULT; bus8.a = 8'd0; bus8.b = 8'd0;
        repeat (2) @(negedge clk);
        check("in_reset_busy", 64'(bus32.busy), 64'd0);
        reset32 = 1'b1; reset8 = 1'b1; bus32.start = 1'b0;
        @(negedge clk);
        check("reset_hilo", {bus32.hi, bus32.lo}, 64'd0);
        check("reset_busy", 64'(bus32.busy), 64'd0);
        check("reset_done", 64'(bus32.done), 64'd0);
        check("reset8_hilo", {48'h0, bus8.hi, bus8.lo}, 64'd0);

        foreach (vecs[i])
            run32(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 33, -1, 0, -1);

        // Signed overflow, with a second start while busy that must be dropped.
        run32("div_overflow_poke", MD_DIV, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, -1, 0, 3);
        any_busy = 0; any_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.busy) any_busy = 1;
            if (bus32.done) any_done = 1;
        end
        check("poke_not_queued_busy", 64'(any_busy), 64'd0);
        check("poke_not_queued_done", 64'(any_done), 64'd0);

        // Five-cycle stall mid-multiply, then done held across a stall.
        run32("mult_stall", MD_MULT, 32'h00000007, 32'hFFFFFFFB, 64'hFFFFFFFF_FFFFFFDD, 33, 10, 5, -1);
        ce = 1'b0;
        repeat (2) @(negedge clk);
        check("done_held_in_stall", 64'(bus32.done), 64'd1);
        ce = 1'b1;
        @(negedge clk);
        check("done_cleared", 64'(bus32.done), 64'd0);

        // Back-to-back moves.
        bus32.start = 1'b1; bus32.op = MD_MTHI; bus32.a = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", 64'(bus32.hi), 64'h12345678);
        check("mthi_busy_done", {62'h0, bus32.busy, bus32.done}, 64'd0);
        bus32.op = MD_MTLO; bus32.a = 32'h9ABCDEF0;
        @(negedge clk);
        check("mtlo_hilo", {bus32.hi, bus32.lo}, 64'h12345678_9ABCDEF0);
        check("mtlo_busy_done", {62'h0, bus32.busy, bus32.done}, 64'd0);

        // Invalid encoding: no state change at all.
        bus32.op = 3'd6; bus32.a = 32'hDEADBEEF; bus32.b = 32'd1;
        any_busy = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus32.busy) any_busy = 1;
        end
        bus32.start = 1'b0;
        check("invalid_op_busy", 64'(any_busy), 64'd0);
        check("invalid_op_hilo", {bus32.hi, bus32.lo}, 64'h12345678_9ABCDEF0);

        // Narrow configuration.
        run8("n8_mult_80_80", MD_MULT,  8'h80, 8'h80, 16'h4000, 3);
        run8("n8_multu_ff_ff", MD_MULTU, 8'hFF, 8'hFF, 16'hFE01, 3);
        run8("n8_div_m127_10", MD_DIV,   8'h81, 8'h0A, 16'hF9F4, 9);
        run8("n8_divu_200_11", MD_DIVU,  8'hC8, 8'h0B, 16'h0212, 9);

        // Reset in the middle of CALC aborts the op without a result.
        bus8.op = MD_MULT; bus8.a = 8'h03; bus8.b = 8'h05; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        check("n8_abort_started", 64'(bus8.busy), 64'd1);
        @(negedge clk);
        reset8 = 1'b0;
        #1;
        check("n8_abort_hilo", {48'h0, bus8.hi, bus8.lo}, 64'd0);
        check("n8_abort_busy_done", {62'h0, bus8.busy, bus8.done}, 64'd0);
        @(negedge clk);
        reset8 = 1'b1;
        any_busy = 0; any_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus8.busy) any_busy = 1;
            if (bus8.done) any_done = 1;
        end
        check("n8_abort_no_busy", 64'(any_busy), 64'd0);
        check("n8_abort_no_done", 64'(any_done), 64'd0);

        check("sb32_drained", 64'(sb32.size()), 64'd0);
        check("sb8_drained", 64'(sb8.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cpu_muldiv.md
Name: mips_cpu_muldiv

Overview:
Parametrised iterative multiply/divide unit owning the HI/LO architectural registers. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO for the core. The core issues an op and stalls on busy; MFHI/MFLO read hi/lo directly. Width and multiply radix are generic so the same block serves the 32-bit core and narrow test configurations.

Parameters:
WIDTH, 32, operand width and HI/LO width; must be at least 4.
MUL_STEP, 1, multiplier bits retired per cycle; must be 1, 2, 4 or 8, and WIDTH must be divisible by MUL_STEP (elaboration assertion).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
clk_enable  input  1  global stall; when low, all state is frozen, including done.
start  input  1  request; sampled only when clk_enable=1.
op  input  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
a  input  WIDTH  rs operand (dividend, multiplicand, or move source).
b  input  WIDTH  rt operand (divisor, multiplier).
busy  output  1  arithmetic op in progress; start is ignored while high.
done  output  1  one-cycle pulse; hi/lo hold the new result this cycle.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, FSM to IDLE, counter=0. Reset during an op aborts it and leaves no partial result.
- An edge advances state only when clk_enable=1. Accept edge: clk_enable=1, start=1, busy=0.
- FSM states: IDLE, CALC, FIX.
  - IDLE: on accept of MTHI/MTLO, write a to hi or lo at that edge. No busy, no done. Stay in IDLE.
  - IDLE: on accept of an arithmetic op, latch operands, load counter N, set busy=1, go to CALC. N = WIDTH/MUL_STEP for multiply, N = WIDTH for divide.
  - CALC: each edge retires one step and decrements the counter. At the edge where the counter reaches 0, go to FIX.
  - FIX: apply sign correction, write hi/lo, set done=1 and busy=0, return to IDLE.
- Latency: busy is high for N+1 cycles after the accept edge. done and the new hi/lo appear on the (N+2)th edge after accept, with the accept edge counted as edge 1. Defaults give MULT 33 busy cycles and DIV 33 busy cycles.
- done is cleared on the next enabled edge. It is held while clk_enable=0.
- Multiply:
  - The {hi,lo} result is the full 2*WIDTH product.
  - Signed ops work on magnitudes and negate in FIX if the operand signs differ.
  - Unsigned ops skip sign correction.
- Divide:
  - lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - Restoring algorithm, one quotient bit per cycle.
- Divide by zero: lo = all ones, hi = a. Same latency, done still pulses.
- Signed overflow (DIV of most-negative value by -1): lo = most-negative value, hi = 0.
- start while busy: ignored and not queued. The core must hold start until busy=0.
- start together with an invalid op encoding: ignored. No state change.
- hi/lo are stable throughout CALC and keep the previous result until FIX.
- clk_enable=0 mid-CALC: counter and partials freeze, and the op resumes unchanged afterwards.

Decomposition:
- Shared package mips_cpu_pkg gets:
  - typedef muldiv_op_t (3-bit enum);
  - typedef muldiv_state_t;
  - constants for the op encodings;
  - a localparam helper giving the counter width, $clog2(WIDTH)+1.
- One sub-module, mips_cpu_muldiv_divider: the iterative restoring divide datapath, magnitude-only, with step/load controls driven by the parent FSM.
- The multiply shift-add datapath and sign fixup stay in the parent.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> hi=0, lo=0, busy=0, done=0. Start ignored while reset=0.
- MULT with a=0xFFFFFFFE (-2), b=0x00000003 -> busy for 33 cycles, done on the 34th edge. hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV with a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007, done still pulses.
- DIV with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Second start while busy -> ignored, and the result matches the first op only.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 in consecutive cycles -> hi/lo are updated the following edges, busy stays 0, done stays 0. Drop clk_enable for 5 cycles mid-MULT -> done is delayed by exactly 5 cycles and the result is unchanged.
- WIDTH=8, MUL_STEP=4: MULT with a=0x80, b=0x80 -> busy for 3 cycles, hi=0x40, lo=0x00. Assert reset mid-CALC -> hi=lo=0, busy=0, no done.
